ima_adpcm_pkt_sequencer: RTL and testbench

//  Packet-level controller that sequences the IMA ADPCM decoder datapath: ima_adpcm_decoder.
//  - Accepts an ADPCM byte stream with valid/ready handshake and a last flag.
//  - Buffers one whole packet, then issues its nibbles gap-free to the decoder.
//    The decoder cannot stall once sop is seen.
//  - Drives the decoder's rst_n, sop, eop and coded_i ports.
//  - Re-times the decoder's decoded_o into a valid/last sample stream.

---
 rtl/ima_adpcm_pkt_sequencer_if.sv | 34 +++
 rtl/ima_adpcm_pkt_sequencer.sv | 161 ++++++++++++++++
 tb/tb_ima_adpcm_pkt_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ima_adpcm_pkt_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ima_adpcm_pkt_sequencer_if : byte-in, decoder and sample-out bundle   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface ima_adpcm_pkt_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        dec_rst_n;
  logic        dec_sop;
  logic        dec_eop;
  logic [3:0]  dec_coded;
  logic [15:0] dec_decoded;
  logic        out_valid;
  logic [15:0] out_sample;
  logic        out_last;
  logic        busy;
  logic        err_oversize;

  modport master (
    input  in_valid, in_data, in_last, dec_decoded,
    output in_ready, dec_rst_n, dec_sop, dec_eop, dec_coded,
    output out_valid, out_sample, out_last, busy, err_oversize
  );

  modport slave (
    output in_valid, in_data, in_last, dec_decoded,
    input  in_ready, dec_rst_n, dec_sop, dec_eop, dec_coded,
    input  out_valid, out_sample, out_last, busy, err_oversize
  );
endinterface
`default_nettype wire

// File: rtl/ima_adpcm_pkt_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ima_adpcm_pkt_sequencer : buffers one ADPCM packet, bursts nibbles    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ima_adpcm_pkt_sequencer #(
  parameter int MAX_BYTES       = 64,
  parameter bit NIBBLE_LO_FIRST = 1'b1,
  parameter bit RESET_PER_PKT   = 1'b1
) (
  input wire logic                  clk,
  input wire logic                  rst,
  ima_adpcm_pkt_sequencer_if.master bus
);
  localparam int CNT_W  = $clog2(MAX_BYTES) + 1;
  localparam int IDX_W  = CNT_W + 1;
  localparam int ADDR_W = $clog2(MAX_BYTES);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRST  = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_mem [MAX_BYTES];
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_nib_idx, w_nib_idx_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_drain, w_drain_nxt;
  logic [1:0]       r_iss_valid;
  logic [1:0]       r_iss_last;
  logic             r_err;

  logic             w_ready;
  logic             w_dec_rst_n;
  logic             w_issue;
  logic             w_sop;
  logic             w_eop;
  logic             w_err_set;
  logic             w_store;
  logic             w_full;
  logic             w_last_nib;
  logic             w_sel_hi;
  logic [7:0]       w_rd_byte;
  logic [3:0]       w_nibble;

  assign w_full     = (r_cnt == MAX_CNT);
  assign w_last_nib = (r_nib_idx == ({r_cnt, 1'b0} - 1'b1));
  assign w_rd_byte  = r_mem[r_nib_idx[ADDR_W:1]];
  assign w_sel_hi   = r_nib_idx[0] ^ !NIBBLE_LO_FIRST;
  assign w_nibble   = w_sel_hi ? w_rd_byte[7:4] : w_rd_byte[3:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_nib_idx_nxt = r_nib_idx;
    w_ovf_nxt     = r_ovf;
    w_drain_nxt   = r_drain;
    w_ready       = 1'b0;
    w_dec_rst_n   = 1'b1;
    w_issue       = 1'b0;
    w_sop         = 1'b0;
    w_eop         = 1'b0;
    w_err_set     = 1'b0;
    w_store       = 1'b0;
    case (r_state)
      FILL: begin
        w_ready = 1'b1;
        if (bus.in_valid) begin
          // Bytes beyond the buffer are still consumed so the source never stalls.
          if (w_full) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_store   = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
          end
          if (bus.in_last && (w_cnt_nxt != '0)) begin
            w_err_set     = w_ovf_nxt;
            w_ovf_nxt     = 1'b0;
            w_nib_idx_nxt = '0;
            if (RESET_PER_PKT) begin
              w_state_nxt = DRST;
            end else begin
              w_state_nxt = BURST;
            end
          end
        end
      end
      DRST: begin
        w_dec_rst_n = 1'b0;
        w_state_nxt = BURST;
      end
      BURST: begin
        w_issue       = 1'b1;
        w_sop         = (r_nib_idx == '0);
        w_eop         = w_last_nib;
        w_nib_idx_nxt = r_nib_idx + 1'b1;
        if (w_last_nib) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = 1'b0;
        end
      end
      DRAIN: begin
        // Two cycles cover the decoder latency so the final sample leaves first.
        w_drain_nxt = 1'b1;
        if (r_drain) begin
          w_state_nxt = FILL;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_nib_idx   <= '0;
      r_ovf       <= 1'b0;
      r_drain     <= 1'b0;
      r_iss_valid <= '0;
      r_iss_last  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_nib_idx   <= w_nib_idx_nxt;
      r_ovf       <= w_ovf_nxt;
      r_drain     <= w_drain_nxt;
      r_iss_valid <= {r_iss_valid[0], w_issue};
      r_iss_last  <= {r_iss_last[0], w_eop};
      r_err       <= w_err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (w_store && !rst) begin
      r_mem[r_cnt[ADDR_W-1:0]] <= bus.in_data;
    end
  end

  // Reset gates every output immediately so in-flight samples are suppressed.
  assign bus.in_ready     = w_ready & ~rst;
  assign bus.dec_rst_n    = w_dec_rst_n & ~rst;
  assign bus.dec_sop      = w_sop & ~rst;
  assign bus.dec_eop      = w_eop & ~rst;
  assign bus.dec_coded    = (w_issue && !rst) ? w_nibble : 4'd0;
  assign bus.out_valid    = r_iss_valid[1] & ~rst;
  assign bus.out_last     = r_iss_last[1] & ~rst;
  assign bus.out_sample   = bus.out_valid ? bus.dec_decoded : 16'd0;
  assign bus.busy         = (r_state != FILL) & ~rst;
  assign bus.err_oversize = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ima_adpcm_pkt_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ima_adpcm_pkt_sequencer : two sequencer variants with an IMA model |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_ima_adpcm_pkt_sequencer;
  localparam int MAXB = 8;

  typedef struct packed {
    logic signed [15:0] p;
    logic [6:0]         i;
  } ima_t;

  typedef struct {
    logic [7:0]  din;
    logic        rst_n;
    logic        sop;
    logic        eop;
    logic [3:0]  coded;
    logic        vout;
    logic [15:0] smp;
    logic        lst;
    logic        bsy;
  } vec_t;

  localparam int STEP [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
    253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
    3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442,
    11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794,
    32767};

  function automatic ima_t ima(input ima_t s, input logic [3:0] n);
    int step, diff, p, i;
    ima_t r;
    step = STEP[int'(s.i)];
    diff = step / 8;
    if (n[2]) diff += step;
    if (n[1]) diff += step / 2;
    if (n[0]) diff += step / 4;
    p = int'(s.p) + (n[3] ? -diff : diff);
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    i = int'(s.i) + (n[2] ? 2 * (int'(n[1:0]) + 1) : -1);
    if (i < 0) i = 0;
    if (i > 88) i = 88;
    r.p = p[15:0];
    r.i = i[6:0];
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ima_adpcm_pkt_sequencer_if bus0();
  ima_adpcm_pkt_sequencer_if bus1();

  ima_adpcm_pkt_sequencer #(.MAX_BYTES(MAXB), .NIBBLE_LO_FIRST(1'b1), .RESET_PER_PKT(1'b1))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ima_adpcm_pkt_sequencer #(.MAX_BYTES(MAXB), .NIBBLE_LO_FIRST(1'b0), .RESET_PER_PKT(1'b0))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [1:0]      vld = '0;
  logic [1:0]      lst = '0;
  logic [1:0][7:0] dat = '0;
  assign bus0.in_valid = vld[0];
  assign bus0.in_last  = lst[0];
  assign bus0.in_data  = dat[0];
  assign bus1.in_valid = vld[1];
  assign bus1.in_last  = lst[1];
  assign bus1.in_data  = dat[1];
  wire [1:0] rdy = {bus1.in_ready, bus0.in_ready};
  wire [1:0] bsy = {bus1.busy, bus0.busy};

  // Decoder stand-ins: state advances only inside a sop..eop window, two-cycle latency.
  ima_t        dst0, dst1, dnx0, dnx1;
  logic        dact0, dact1;
  logic [15:0] ds0, ds1, dd0, dd1;
  assign dnx0 = ima(dst0, bus0.dec_coded);
  assign dnx1 = ima(dst1, bus1.dec_coded);
  assign bus0.dec_decoded = dd0;
  assign bus1.dec_decoded = dd1;

  always @(posedge clk) begin
    if (!bus0.dec_rst_n) begin
      dst0 <= '0; dact0 <= 1'b0; ds0 <= '0; dd0 <= '0;
    end else begin
      if (bus0.dec_sop || dact0) begin
        dst0 <= dnx0; ds0 <= dnx0.p; dact0 <= !bus0.dec_eop;
      end
      dd0 <= ds0;
    end
    if (!bus1.dec_rst_n) begin
      dst1 <= '0; dact1 <= 1'b0; ds1 <= '0; dd1 <= '0;
    end else begin
      if (bus1.dec_sop || dact1) begin
        dst1 <= dnx1; ds1 <= dnx1.p; dact1 <= !bus1.dec_eop;
      end
      dd1 <= ds1;
    end
  end

  logic [17:0] got [$];
  logic [17:0] expq [$];
  int errc0 = 0;
  int errc1 = 0;

  always @(negedge clk) begin
    if (bus0.out_valid) got.push_back({1'b0, bus0.out_last, bus0.out_sample});
    if (bus1.out_valid) got.push_back({1'b1, bus1.out_last, bus1.out_sample});
    if (bus0.err_oversize) errc0 <= errc0 + 1;
    if (bus1.err_oversize) errc1 <= errc1 + 1;
  end

  int   checks = 0;
  int   fails  = 0;
  ima_t mst0, mst1;
  logic [7:0] pkt [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Reference: truncate to MAXB bytes, split into nibbles, decode each one in order.
  task automatic expect_pkt(input int s);
    int         k;
    ima_t       st;
    logic [7:0] b;
    logic [3:0] nib;
    k  = (pkt.size() > MAXB) ? MAXB : pkt.size();
    st = (s == 0) ? '0 : mst1;
    for (int i = 0; i < k; i++) begin
      b = pkt[i];
      for (int h = 0; h < 2; h++) begin
        if (s == 0) nib = (h == 0) ? b[3:0] : b[7:4];
        else        nib = (h == 0) ? b[7:4] : b[3:0];
        st = ima(st, nib);
        expq.push_back({(s != 0), (i == k - 1) && (h == 1), st.p});
      end
    end
    if (s == 0) mst0 = st; else mst1 = st;
  endtask

  task automatic send_byte(input int s, input logic [7:0] b, input logic l, output int stall);
    vld[s] = 1'b1; dat[s] = b; lst[s] = l; stall = 0;
    while (!rdy[s] && stall < 500) begin
      @(posedge clk); #1; stall++;
    end
    if (stall >= 500) chk("ready_timeout", 32'(rdy[s]), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int s);
    int t;
    t = 0;
    while (bsy[s] && t < 400) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 400) chk("idle_timeout", 32'(bsy[s]), 32'd0);
  endtask

  task automatic compare();
    chk("sample_count", got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk($sformatf("sample[%0d]", i), 32'(got[i]), 32'(expq[i]));
    got.delete();
    expq.delete();
  endtask

  task automatic send_pkt(input int s, input bit gaps);
    int e0, st, ovr;
    expect_pkt(s);
    e0  = (s == 0) ? errc0 : errc1;
    ovr = (pkt.size() > MAXB) ? 1 : 0;
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        vld[s] = 1'b0; @(posedge clk); #1;
      end
      send_byte(s, pkt[i], i == pkt.size() - 1, st);
    end
    vld[s] = 1'b0;
    wait_idle(s);
    compare();
    chk("err_oversize_pulses", ((s == 0) ? errc0 : errc1) - e0, ovr);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(rdy), 32'd0);
    chk({tag, "_dec_rst_n"}, 32'({bus1.dec_rst_n, bus0.dec_rst_n}), 32'd0);
    chk({tag, "_sop_eop"}, 32'({bus1.dec_sop, bus1.dec_eop, bus0.dec_sop, bus0.dec_eop}), 32'd0);
    chk({tag, "_coded"}, 32'({bus1.dec_coded, bus0.dec_coded}), 32'd0);
    chk({tag, "_out"}, 32'({bus1.out_valid, bus1.out_last, bus0.out_valid, bus0.out_last}), 32'd0);
    chk({tag, "_busy_err"}, 32'({bsy, bus1.err_oversize, bus0.err_oversize}), 32'd0);
  endtask

  vec_t vt [12];

  initial begin
    int st, t, n0;
    vec_t v;
    // Cycles c0..c5 after a one-byte packet is accepted: DRST, 2 nibbles, 2 drain cycles, idle.
    vt[0]  = '{8'h44, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 16'd0,  1'b0, 1'b1};
    vt[1]  = '{8'h44, 1'b1, 1'b1, 1'b0, 4'h4, 1'b0, 16'd0,  1'b0, 1'b1};
    vt[2]  = '{8'h44, 1'b1, 1'b0, 1'b1, 4'h4, 1'b0, 16'd0,  1'b0, 1'b1};
    vt[3]  = '{8'h44, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 16'd7,  1'b0, 1'b1};
    vt[4]  = '{8'h44, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 16'd17, 1'b1, 1'b1};
    vt[5]  = '{8'h44, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 16'd0,  1'b0, 1'b0};
    vt[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 16'd0,  1'b0, 1'b1};
    vt[7]  = '{8'h00, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 16'd0,  1'b0, 1'b1};
    vt[8]  = '{8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 16'd0,  1'b0, 1'b1};
    vt[9]  = '{8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 16'd0,  1'b0, 1'b1};
    vt[10] = '{8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 16'd0,  1'b1, 1'b1};
    vt[11] = '{8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 16'd0,  1'b0, 1'b0};

    mst0 = '0; mst1 = '0;
    vld[0] = 1'b1; vld[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    vld = '0;
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 32'(rdy), 32'd3);

    for (int g = 0; g < 2; g++) begin
      send_byte(0, vt[g*6].din, 1'b1, st);
      vld[0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
        v = vt[g*6 + k];
        chk($sformatf("vec%0d_dec_rst_n", g*6+k), 32'(bus0.dec_rst_n), 32'(v.rst_n));
        chk($sformatf("vec%0d_sop_eop", g*6+k), 32'({bus0.dec_sop, bus0.dec_eop}), 32'({v.sop, v.eop}));
        chk($sformatf("vec%0d_coded", g*6+k), 32'(bus0.dec_coded), 32'(v.coded));
        chk($sformatf("vec%0d_valid_last", g*6+k), 32'({bus0.out_valid, bus0.out_last}), 32'({v.vout, v.lst}));
        chk($sformatf("vec%0d_busy", g*6+k), 32'(bus0.busy), 32'(v.bsy));
        if (v.vout) chk($sformatf("vec%0d_sample", g*6+k), 32'(bus0.out_sample), 32'(v.smp));
        @(posedge clk); #1;
      end
    end
    got.delete();

    // Decoder state carries across packets on the no-reset variant.
    pkt = '{8'h44, 8'h00}; send_pkt(1, 1'b0);
    pkt = '{8'h04};        send_pkt(1, 1'b0);

    // Oversize packet and an exactly-full packet.
    pkt.delete();
    for (int i = 0; i < MAXB + 4; i++) pkt.push_back(8'($urandom));
    send_pkt(0, 1'b0);
    pkt.delete();
    for (int i = 0; i < MAXB; i++) pkt.push_back(8'($urandom));
    send_pkt(0, 1'b0);

    // in_valid held across the packet boundary: stall covers DRST + 2N nibbles + drain.
    pkt = '{8'h12, 8'h9a, 8'h7f};
    expect_pkt(0);
    send_byte(0, 8'h12, 1'b0, st);
    send_byte(0, 8'h9a, 1'b0, st);
    send_byte(0, 8'h7f, 1'b1, st);
    pkt = '{8'hc3, 8'h5e};
    expect_pkt(0);
    send_byte(0, 8'hc3, 1'b0, st);
    chk("stall_cycles", st, 2*3 + 3);
    send_byte(0, 8'h5e, 1'b1, st);
    vld[0] = 1'b0;
    wait_idle(0);
    compare();

    // Reset in the middle of a burst.
    send_byte(0, 8'h44, 1'b0, st);
    send_byte(0, 8'h44, 1'b0, st);
    send_byte(0, 8'h44, 1'b1, st);
    vld[0] = 1'b0;
    t = 0;
    while (!bus0.dec_sop && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("burst_started", 32'(bus0.dec_sop), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n0 = got.size();
    chk("rst_dec_rst_n", 32'(bus0.dec_rst_n), 32'd0);
    chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    @(posedge clk); #1;
    check_reset_outputs("midburst");
    rst = 1'b0;
    mst1 = '0;
    repeat (6) @(posedge clk);
    #1;
    chk("no_samples_after_rst", got.size(), n0);
    chk("idle_after_rst", 32'({rdy, bsy}), 32'({2'b11, 2'b00}));
    got.delete();
    pkt = '{8'h44}; send_pkt(0, 1'b0);

    for (int r = 0; r < 16; r++) begin
      int s, n;
      s = $urandom_range(0, 1);
      n = $urandom_range(1, MAXB + 3);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      send_pkt(s, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire
